// File: rtl/demux_1x2.sv
// Registered 1-to-2 valid/ready stream demultiplexer with a one-entry register per output.
// Define DEMUX_PKT_LOCK_EN to steer whole packets by the select sampled on their first beat.
module demux_1x2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_sel,
  input  logic             in_last,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  output logic             out0_last,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  output logic             out1_last,
  input  logic             out1_ready
);

  logic esel;
  logic in_xfer;
  logic load0;
  logic load1;

`ifdef DEMUX_PKT_LOCK_EN
  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } lock_state_e;

  lock_state_e state, state_nxt;
  logic        lock_sel, lock_sel_nxt;

  // esel is kept apart from the next-state logic: in_xfer depends on esel, so
  // folding both into one process would create a false combinational loop.
  assign esel = (state == PKT) ? lock_sel : in_sel;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      lock_sel <= 1'b0;
    end else begin
      state    <= state_nxt;
      lock_sel <= lock_sel_nxt;
    end
  end

  // NOTE: defaults first so no path through the case leaves an output unassigned
  // (which would infer a latch).
  always_comb begin
    state_nxt    = state;
    lock_sel_nxt = lock_sel;
    case (state)
      IDLE: if (in_xfer && !in_last) begin
        state_nxt    = PKT;
        lock_sel_nxt = in_sel;
      end
      PKT: if (in_xfer && in_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
`else
  assign esel = in_sel;
`endif

  // Ready looks only at the selected register, so a stalled consumer never blocks the other.
  assign in_ready = rst_n & (esel ? (~out1_valid | out1_ready) : (~out0_valid | out0_ready));
  assign in_xfer  = in_valid & in_ready;
  assign load0    = in_xfer & ~esel;
  assign load1    = in_xfer & esel;

  // NOTE: data/last are reset too, because outputs must read 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out0_data  <= '0;
      out0_last  <= 1'b0;
      out0_valid <= 1'b0;
    end else if (load0) begin
      out0_data  <= in_data;
      out0_last  <= in_last;
      out0_valid <= 1'b1;
    end else if (out0_ready) begin
      out0_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out1_data  <= '0;
      out1_last  <= 1'b0;
      out1_valid <= 1'b0;
    end else if (load1) begin
      out1_data  <= in_data;
      out1_last  <= in_last;
      out1_valid <= 1'b1;
    end else if (out1_ready) begin
      out1_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_demux_1x2.sv
// Scoreboard bench for demux_1x2: directed scenarios followed by randomized traffic.
// Honours DEMUX_PKT_LOCK_EN in its reference model the same way the design does.
module tb_demux_1x2;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_sel = 1'b0;
  logic         in_last = 1'b0;
  logic         in_ready;
  logic [W-1:0] out0_data, out1_data;
  logic         out0_valid, out1_valid, out0_last, out1_last;
  logic         out0_ready = 1'b0;
  logic         out1_ready = 1'b0;

  demux_1x2 #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_sel(in_sel), .in_last(in_last),
    .in_ready(in_ready),
    .out0_data(out0_data), .out0_valid(out0_valid), .out0_last(out0_last),
    .out0_ready(out0_ready),
    .out1_data(out1_data), .out1_valid(out1_valid), .out1_last(out1_last),
    .out1_ready(out1_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         last;
    logic [W-1:0] data;
  } beat_t;

  beat_t q0[$];
  beat_t q1[$];
  int    checks = 0;
  int    failures = 0;
  bit    mon_en = 1'b0;
  bit    rdy_rand = 1'b0;
  bit    in_pkt = 1'b0;
  logic  pkt_dest = 1'b0;
  bit    hold_v0 = 1'b0, hold_v1 = 1'b0;
  beat_t hold_b0, hold_b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Destination of the next beat: the packet's first-beat select while a packet is open.
  function automatic logic model_dest(input logic sel);
`ifdef DEMUX_PKT_LOCK_EN
    return in_pkt ? pkt_dest : sel;
`else
    return sel;
`endif
  endfunction

  task automatic model_accept(input beat_t b, input logic sel);
    logic d;
    d = model_dest(sel);
    if (d) q1.push_back(b);
    else   q0.push_back(b);
`ifdef DEMUX_PKT_LOCK_EN
    if (!in_pkt && !b.last) begin
      in_pkt   = 1'b1;
      pkt_dest = sel;
    end else if (in_pkt && b.last) begin
      in_pkt = 1'b0;
    end
`endif
  endtask

  // Called at posedge+1; holds the beat until accepted and returns cycles spent.
  task automatic drive_beat(input logic [W-1:0] d, input logic s, input logic l, output int cyc);
    bit acc;
    acc = 1'b0;
    cyc = 0;
    in_data = d; in_sel = s; in_last = l; in_valid = 1'b1;
    while (!acc && cyc < 500) begin
      @(negedge clk);
      cyc++;
      acc = in_ready;
      if (acc) begin
        #1 model_accept({l, d}, s);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=no_accept expected=accept data=%0h", d);
    end
  endtask

  // Monitor: pops the scoreboard whenever an output transfers.
  always @(negedge clk) begin
    if (mon_en) begin
      logic  dst;
      logic  exp_ir;
      beat_t e;
      dst    = model_dest(in_sel);
      exp_ir = dst ? ((q1.size() == 0) | out1_ready) : ((q0.size() == 0) | out0_ready);
      check("in_ready", in_ready, exp_ir);
      check("out0_valid", out0_valid, q0.size() != 0);
      check("out1_valid", out1_valid, q1.size() != 0);
      if (hold_v0) check("out0_stable", {out0_last, out0_data}, hold_b0);
      if (hold_v1) check("out1_stable", {out1_last, out1_data}, hold_b1);
      if (out0_valid && out0_ready) begin
        if (q0.size() == 0) check("out0_unexpected", 1, 0);
        else begin
          e = q0.pop_front();
          check("out0_beat", {out0_last, out0_data}, e);
        end
      end
      if (out1_valid && out1_ready) begin
        if (q1.size() == 0) check("out1_unexpected", 1, 0);
        else begin
          e = q1.pop_front();
          check("out1_beat", {out1_last, out1_data}, e);
        end
      end
      hold_v0 = out0_valid & ~out0_ready;
      hold_b0 = {out0_last, out0_data};
      hold_v1 = out1_valid & ~out1_ready;
      hold_b1 = {out1_last, out1_data};
    end else begin
      hold_v0 = 1'b0;
      hold_v1 = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (rdy_rand) begin
      #1;
      out0_ready = ($urandom_range(0, 9) < 6);
      out1_ready = ($urandom_range(0, 9) < 6);
    end
  end

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_valids"}, {out0_valid, out1_valid}, 0);
    check({tag, "_data"}, {out0_data, out1_data}, 0);
    check({tag, "_last"}, {out0_last, out1_last}, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c, total;
    logic [W-1:0] alt_d[4];
    alt_d = '{8'h11, 8'h22, 8'h33, 8'h44};

    repeat (2) @(posedge clk);
    #1 check_reset_state("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 mon_en = 1'b1;

    // Alternating steer with both consumers ready.
    out0_ready = 1'b1; out1_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_beat(alt_d[i], i[0], 1'b1, c);
      check("alt_accept_cycles", c, 1);
    end
    repeat (2) @(posedge clk);
    #1;

    // Independent back-pressure.
    out0_ready = 1'b0; out1_ready = 1'b1;
    drive_beat(8'hA5, 1'b0, 1'b1, c);
    drive_beat(8'h5A, 1'b1, 1'b1, c);
    check("bp_other_accept", c, 1);
    check("bp_out1_data", out1_data, 8'h5A);
    fork
      drive_beat(8'h3C, 1'b0, 1'b1, c);
      begin
        repeat (4) begin
          @(negedge clk);
          check("bp_blocked", in_ready, 0);
          check("bp_hold", out0_data, 8'hA5);
        end
        @(posedge clk);
        #1 out0_ready = 1'b1;
      end
    join
    check("bp_wait_cycles", c, 5);
    repeat (2) @(posedge clk);
    #1;

    // Simultaneous drain/load, then an 8-beat stream at full rate.
    out1_ready = 1'b0;
    drive_beat(8'h66, 1'b1, 1'b1, c);
    out1_ready = 1'b1;
    total = 0;
    for (int i = 0; i < 8; i++) begin
      drive_beat(8'h77 + W'(i), 1'b1, 1'b1, c);
      total += c;
      if (i == 0) begin
        check("dl_out1_valid", out1_valid, 1);
        check("dl_out1_data", out1_data, 8'h77);
      end
    end
    check("stream_8_cycles", total, 8);
    repeat (2) @(posedge clk);
    #1;

    // Three-beat packet whose select changes after the first beat.
    drive_beat(8'h01, 1'b1, 1'b0, c);
    drive_beat(8'h02, 1'b0, 1'b0, c);
    drive_beat(8'h03, 1'b0, 1'b1, c);
`ifdef DEMUX_PKT_LOCK_EN
    check("pkt_tail_out1", {out1_valid, out1_last, out1_data}, {2'b11, 8'h03});
`else
    check("pkt_tail_out0", {out0_valid, out0_last, out0_data}, {2'b11, 8'h03});
`endif
    drive_beat(8'h04, 1'b0, 1'b1, c);
    check("pkt_next_out0", {out0_valid, out0_data}, {1'b1, 8'h04});
    repeat (2) @(posedge clk);
    #1;

    // Asynchronous reset with both outputs holding beats.
    out0_ready = 1'b0; out1_ready = 1'b0;
    drive_beat(8'hC1, 1'b0, 1'b1, c);
    drive_beat(8'hC2, 1'b1, 1'b1, c);
    check("pre_reset_valids", {out0_valid, out1_valid}, 2'b11);
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_state("async_reset");
    q0.delete(); q1.delete(); in_pkt = 1'b0; pkt_dest = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 mon_en = 1'b1;

    // Randomized traffic with random back-pressure and idle gaps.
    rdy_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      drive_beat(W'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0), c);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    rdy_rand = 1'b0;
    @(posedge clk);
    #2 out0_ready = 1'b1; out1_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("drain_q0_empty", q0.size(), 0);
    check("drain_q1_empty", q1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux_1x2.md
# demux_1x2

Registered 1-to-2 stream demultiplexer: the receive-side counterpart of the team's 2x1 multiplexer. One valid/ready input stream is steered, beat by beat or packet by packet, to one of two valid/ready output streams. Each output has a one-entry output register, so all outputs are registered and back-pressure on one output never blocks beats addressed to the other. It sits downstream of a shared link and fans traffic out to two consumers.

## Interface
- WIDTH, 8: data width of input and both outputs, in bits (≥1).
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  WIDTH  input beat payload.
- in_valid  input  1  input beat present.
- in_sel  input  1  destination: 0 → out0, 1 → out1.
- in_last  input  1  final beat of packet.
- in_ready  output  1  input beat accepted this cycle when in_valid is also high.
- out0_data / out1_data  output  WIDTH  registered payload.
- out0_valid / out1_valid  output  1  output register holds a beat.
- out0_last / out1_last  output  1  registered copy of in_last.
- out0_ready / out1_ready  input  1  consumer accepts the beat.

## Operation
- Transfer: input transfer = in_valid & in_ready; output k transfer = outk_valid & outk_ready.
- Effective select `esel`: in_sel, or the locked select (see Configuration).
- in_ready = rst_n & (~out[esel]_valid | out[esel]_ready). Combinational from esel and the selected register's state only. Never depends on the unselected output.
- On input transfer: out[esel]_data ← in_data, out[esel]_last ← in_last, out[esel]_valid ← 1.
- On output k transfer with no new beat into k: outk_valid ← 0. Data and last hold their value.
- Same cycle output k drains and input loads k: outk_valid stays 1 and the new beat replaces the old one. Full throughput of 1 beat/cycle per output.
- While outk_valid=1 and outk_ready=0: outk_data and outk_last are stable.
- Beats to the same output leave in arrival order. No ordering exists between out0 and out1.
- No beat is dropped or duplicated.

## Timing
- Latency: an input beat accepted at edge N appears on outk at edge N (visible in cycle N+1). One register stage.
- Reset (rst_n low, asynchronous): out0/out1_valid=0, _data=0, _last=0; in_ready=0; lock state=IDLE, locked select=0. Reset mid-beat discards any held beats. The first transfer is possible in the first cycle after rst_n rises.
- in_valid may assert without waiting for in_ready. Once in_valid is high, the source holds data/sel/last until transfer.

## Configuration
- DEMUX_PKT_LOCK_EN defined: a 2-state FSM selects between the sampled and the locked select.
  - IDLE: esel = in_sel.
    - A transfer with in_last=0 latches in_sel into the locked select and moves to PKT.
    - A transfer with in_last=1 stays in IDLE.
  - PKT: esel = locked select; in_sel is ignored.
    - A transfer with in_last=1 returns to IDLE.
  - Effect: a whole packet goes to the output chosen on its first beat.
- Not defined: no FSM; esel = in_sel on every beat; in_last is only passed through.

## Test plan
- Reset: assert rst_n=0 mid-stream with both outputs holding beats → all valids/data/last 0 and in_ready=0 immediately, without waiting for clk.
- Alternating steer: 4 beats 0x11,0x22,0x33,0x44 with sel 0,1,0,1, both readies high → out0 gets 0x11,0x33, out1 gets 0x22,0x44. Each appears one edge after acceptance; in_ready stays 1.
- Independent back-pressure: out0_ready=0 with out0 holding 0xA5; send 0x5A with sel=1 → accepted, out1_data=0x5A. Send sel=0 → in_ready=0 and out0 holds 0xA5 stable until out0_ready=1.
- Simultaneous drain/load: out1 full, out1_ready=1, input 0x77 with sel=1 → out1_valid stays 1 and out1_data=0x77 next cycle. Streaming 8 beats takes exactly 8 cycles.
- With DEMUX_PKT_LOCK_EN: 3-beat packet 0x01,0x02,0x03 with sel=1,0,0 and last on the third beat → all three on out1. The next beat with sel=0 goes to out0.
- Without DEMUX_PKT_LOCK_EN: same stimulus → 0x01 to out1, 0x02 and 0x03 to out0, out0_last=1 on 0x03.
